// File: rtl/v_hier_sub_array.sv
// Parameterised FIFO of WIDTH-bit channel vectors with a per-channel output
// transform (pass / invert / bit-reverse) and a sticky overflow flag.
module v_hier_sub_array #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           avec,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           qvec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != {CW{1'b0}});
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    // Explicit wrap so non-power-of-two depths roll over at DEPTH-1.
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (in_valid && (count_q == CW'(DEPTH))) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage holds raw input words and is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= avec;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic bit_s;
    if (MODE == 1) begin : g_inv
      assign bit_s = ~head[i];
    end else if (MODE == 2) begin : g_rev
      assign bit_s = head[WIDTH-1-i];
    end else begin : g_pass
      assign bit_s = head[i];
    end
    assign qvec[i] = out_valid & bit_s;
  end

endmodule

// File: doc/v_hier_sub_array.md
V_HIER_SUB_ARRAY -- requirements
Module: v_hier_sub_array

Interface
REQ-001 SHALL have parameter WIDTH, default 4: channel count, i.e. the bit width of avec and qvec; legal range 1..64.
REQ-002 SHALL have parameter DEPTH, default 4: number of buffer entries; legal range 2..256, need not be a power of two.
REQ-003 SHALL have parameter MODE, default 0: per-channel transform (0 = pass, 1 = invert, 2 = bit-reverse across channels).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the producer offers avec this cycle.
REQ-007 SHALL have port avec, input, WIDTH bits: the input channel vector.
REQ-008 SHALL have port in_ready, output, 1 bit: the block can accept a push this cycle.
REQ-009 SHALL have port qvec, output, WIDTH bits: the transformed head entry.
REQ-010 SHALL have port out_valid, output, 1 bit: qvec holds a valid entry.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes qvec this cycle.
REQ-012 SHALL have port count, output, clog2(DEPTH+1) bits: the current occupancy.
REQ-013 SHALL have port ovf, output, 1 bit: sticky overflow flag.

Function
REQ-014 SHALL implement a DEPTH-entry FIFO of WIDTH-bit words.
REQ-015 SHALL define push as in_valid && in_ready, and pop as out_valid && out_ready.
REQ-016 SHALL drive in_ready = (count != DEPTH), combinationally from registered state only; it SHALL NOT depend on out_ready.
REQ-017 SHALL drive out_valid = (count != 0).
REQ-018 SHALL drive qvec = MODE transform of the head entry when out_valid is 1, and all-zero when out_valid is 0.
REQ-019 SHALL apply the MODE transform on the output path only; stored words SHALL be the raw avec values.
REQ-020 SHALL define MODE 2 as qvec[i] = head[WIDTH-1-i].
REQ-021 SHALL define MODE 1 as qvec = ~head.
REQ-022 SHALL treat any other MODE value as pass.
REQ-023 SHALL have a latency of one cycle: a word pushed at edge t is visible on qvec with out_valid=1 after edge t when the FIFO was empty.
REQ-024 SHALL order words strictly first-in first-out.
REQ-025 SHALL wrap the write and read pointers from DEPTH-1 to 0; non-power-of-two DEPTH SHALL wrap correctly.
REQ-026 SHALL, on simultaneous push and pop, update both pointers and leave count unchanged.
REQ-027 SHALL, when empty with in_valid=1, accept the push; no pop occurs that cycle, because out_valid=0 and there is no fall-through.
REQ-028 SHALL, when full with in_valid=1 and out_ready=1, perform the pop only, reject the push, and set ovf.
REQ-029 SHALL set ovf at the edge where in_valid=1 and count==DEPTH, and hold it at 1 until rst.
REQ-030 SHALL leave pointers, count and storage unchanged when out_ready=1 and out_valid=0.
REQ-031 SHALL keep count in the range 0..DEPTH at all times.
REQ-032 SHALL build the per-channel output mux with a generate loop over WIDTH.

Reset
REQ-033 SHALL, while rst=1, immediately and without a clock drive: count=0, out_valid=0, in_ready=1, qvec=0, ovf=0, and both pointers=0.
REQ-034 SHALL NOT require storage contents to be reset.
REQ-035 SHALL discard all buffered words when rst is asserted mid-operation; the first push after release SHALL appear as the head.
REQ-036 SHALL register a push on the first rising edge after rst deasserts.

Verification
REQ-037 SHALL cover basic pass (WIDTH=4, DEPTH=4, MODE=0): push 4'hA, then 4'h3 with out_ready=0 -> count=2, qvec=4'hA; then out_ready=1 for 2 cycles -> qvec=4'h3, then out_valid=0 and qvec=0.
REQ-038 SHALL cover full/overflow: push 5 words 1..5 with out_ready=0 -> in_ready=0 after the 4th, the 5th is rejected, ovf=1, count=4; drain -> 1,2,3,4 in order and ovf stays 1.
REQ-039 SHALL cover full with simultaneous push/pop: count=4, in_valid=1, out_ready=1 for one cycle -> count=3, head advances, ovf=1.
REQ-040 SHALL cover wrap with DEPTH=3: stream 10 words with in_valid=1 and out_ready=1 continuously -> count stays 1 after the first push, and output order matches input order.
REQ-041 SHALL cover the transforms with WIDTH=4: MODE=1 push 4'b0011 -> qvec=4'b1100; MODE=2 push 4'b0001 -> qvec=4'b1000.
REQ-042 SHALL cover asynchronous reset mid-stream: count=2, assert rst between clock edges -> outputs reach their reset values before the next edge; after release, push 4'h7 -> qvec=4'h7 and count=1.
